// File: rtl/fwft_pkg.sv
// Shared types for the FWFT read sequencer: output-buffer occupancy encoding and depth.
package fwft_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } fwft_occ_e;

  localparam int unsigned OUT_DEPTH = 2;

  // Occupancy as a 3-bit count, wide enough for occupancy + one in-flight read.
  function automatic logic [2:0] occ_count(input fwft_occ_e occ);
    return {1'b0, occ};
  endfunction

endpackage

// File: rtl/fwft_skid_buf.sv
// Two-entry output buffer (main + skid) with occupancy FSM; main always holds the oldest word.
module fwft_skid_buf
  import fwft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  flush,
  input  logic                  land,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output fwft_occ_e             occ
);

  fwft_occ_e             occ_q, occ_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;

  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      // Registers keep their contents; only the occupancy is discarded.
      occ_d = OCC_EMPTY;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (land) begin
            occ_d  = OCC_ONE;
            main_d = din;
          end
        end
        OCC_ONE: begin
          if (land && !pop) begin
            occ_d  = OCC_TWO;
            skid_d = din;
          end else if (land && pop) begin
            main_d = din;
          end else if (pop) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            main_d = skid_q;
            if (land) begin
              skid_d = din;
            end else begin
              occ_d = OCC_ONE;
            end
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      occ_q  <= OCC_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign dout       = main_q;
  assign dout_valid = (occ_q != OCC_EMPTY);
  assign occ        = occ_q;

  // Credit logic upstream must never let a word land into a full, stalled buffer.
  a_no_land_when_full: assert property (@(posedge clk) disable iff (arst)
    !(occ_q == OCC_TWO && land && !pop));

  a_occ_legal: assert property (@(posedge clk) disable iff (arst)
    (occ_q == OCC_EMPTY) || (occ_q == OCC_ONE) || (occ_q == OCC_TWO));

endmodule

// File: rtl/fwft_rd_sequencer.sv
// Turns a FIFO with 1-cycle registered read into a first-word-fall-through valid/ready stream.
module fwft_rd_sequencer
  import fwft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  logic      inflight_q;
  logic      pop;
  logic      land;
  logic      credit_ok;
  logic [2:0] pending;
  fwft_occ_e occ;

  assign pop  = dout_valid & dout_ready;
  assign land = inflight_q & ~flush;

  // Words held or on their way must fit in the buffer after this cycle's pop.
  assign pending   = occ_count(occ) + {2'b00, inflight_q};
  assign credit_ok = pending < (3'(OUT_DEPTH) + {2'b00, pop});
  assign fifo_rd_en = ~arst & ~fifo_empty & ~flush & credit_ok;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
    end
  end

  fwft_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .arst      (arst),
    .flush     (flush),
    .land      (land),
    .pop       (pop),
    .din       (fifo_rd_data),
    .dout      (dout),
    .dout_valid(dout_valid),
    .occ       (occ)
  );

  a_no_read_on_empty: assert property (@(posedge clk) disable iff (arst)
    !(fifo_rd_en && fifo_empty));

endmodule
